// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a 0x55 sync character on the synchronised rxd line,
// derives the 16x baud divider and gates the RX FSM enable until a divider is locked.
module uart_autobaud_ctrl #(
  parameter int CNT_W    = 20,
  parameter int DIV_W    = 12,
  parameter int SYNC_STG = 2
) (
  input  logic             app_clk,
  input  logic             reset_n,
  input  logic             cfg_autobaud_en,
  input  logic             cfg_autobaud_start,
  input  logic             cfg_rx_enable,
  input  logic [DIV_W-1:0] cfg_baud_div_dflt,
  input  logic             si,
  output logic [DIV_W-1:0] baud_div,
  output logic             baud_div_upd,
  output logic             rx_enable,
  output logic             ab_locked,
  output logic             ab_error
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_FE, MEASURE, CALC, WAIT_STOP, LOCKED, ERR
  } state_t;

  state_t              state;
  logic [SYNC_STG-1:0] si_sync;
  logic                line_p0;
  logic                line_p1;
  logic                fe;
  logic                re;
  logic [CNT_W-1:0]    icnt;
  logic [CNT_W-1:0]    tcnt;
  logic [CNT_W:0]      i1;
  logic [CNT_W:0]      ik;
  logic [2:0]          edge_n;
  logic [DIV_W-1:0]    div_meas;
  logic [31:0]         div_raw;
  logic                icnt_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Eight bit-times hold 128 ticks of the 16x clock; round to nearest.
  function automatic logic [31:0] round_div(input logic [CNT_W-1:0] t);
    return (32'(t) + 32'd64) >> 7;
  endfunction

  function automatic logic interval_bad(input logic [CNT_W:0] ik_v, input logic [CNT_W:0] i1_v);
    logic signed [CNT_W+1:0] diff;
    logic        [CNT_W+1:0] mag;
    diff = $signed({1'b0, ik_v}) - $signed({1'b0, i1_v});
    mag  = diff[CNT_W+1] ? $unsigned(-diff) : $unsigned(diff);
    return mag > {1'b0, (i1_v >> 3)};
  endfunction

  assign line_p0  = si_sync[SYNC_STG-1];
  assign fe       = line_p1 & ~line_p0;
  assign re       = ~line_p1 & line_p0;
  assign ik       = {1'b0, icnt} + (CNT_W+1)'(1);
  assign div_raw  = round_div(tcnt);
  assign icnt_max = &icnt;

  // Stage p0: synchroniser output; stage p1: edge-detect history
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      si_sync <= '1;
      line_p1 <= 1'b1;
    end else begin
      si_sync <= {si_sync[SYNC_STG-2:0], si};
      line_p1 <= line_p0;
    end
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_div  <= '0;
      rx_enable <= 1'b0;
    end else begin
      baud_div  <= (cfg_autobaud_en && ab_locked) ? div_meas : cfg_baud_div_dflt;
      rx_enable <= cfg_rx_enable && (!cfg_autobaud_en || ab_locked);
    end
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      icnt         <= '0;
      tcnt         <= '0;
      i1           <= '0;
      edge_n       <= '0;
      div_meas     <= '0;
      ab_locked    <= 1'b0;
      baud_div_upd <= 1'b0;
      ab_error     <= 1'b0;
    end else begin
      baud_div_upd <= 1'b0;
      ab_error     <= 1'b0;
      // Disable beats re-arm, and re-arm beats any edge seen this cycle.
      if (!cfg_autobaud_en) begin
        state     <= IDLE;
        ab_locked <= 1'b0;
        icnt      <= '0;
        tcnt      <= '0;
        edge_n    <= '0;
      end else if (cfg_autobaud_start && state != IDLE) begin
        state     <= ARM;
        ab_locked <= 1'b0;
        icnt      <= '0;
        tcnt      <= '0;
        edge_n    <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: if (line_p0) state <= WAIT_FE;
          WAIT_FE: begin
            if (fe) begin
              icnt   <= '0;
              tcnt   <= '0;
              edge_n <= 3'd1;
              state  <= MEASURE;
            end
          end
          MEASURE: begin
            icnt <= sat_inc(icnt);
            tcnt <= sat_inc(tcnt);
            if (fe) begin
              icnt   <= '0;
              edge_n <= edge_n + 3'd1;
              if (edge_n == 3'd1) i1 <= ik;
              else if (interval_bad(ik, i1)) state <= ERR;
              else if (edge_n == 3'd4) state <= CALC;
            end else if (icnt_max) begin
              state <= ERR;
            end
          end
          CALC: begin
            if (div_raw == 32'd0 || div_raw > (32'd1 << DIV_W)) begin
              state <= ERR;
            end else begin
              div_meas <= DIV_W'(div_raw - 32'd1);
              state    <= WAIT_STOP;
            end
          end
          WAIT_STOP: begin
            icnt <= sat_inc(icnt);
            if (re) begin
              ab_locked    <= 1'b1;
              baud_div_upd <= 1'b1;
              state        <= LOCKED;
            end else if (icnt_max) begin
              state <= ERR;
            end
          end
          LOCKED: state <= LOCKED;
          ERR: begin
            ab_error  <= 1'b1;
            ab_locked <= 1'b0;
            state     <= ARM;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
